// File: rtl/dec_adjust_pkg.sv
// dec_adjust_pkg -- shared definitions for the decimal-adjust pipeline.
//   ADJ_LO / ADJ_HI / BCD_MAX : BCD correction constants
//   flags_t                   : {c, n, z, v} flag bundle
//   op_t                      : ADC / SBC operation encoding
//   front_t / back_t          : stage-1 and stage-2 payloads
//   apply_adjust()            : stage-2 work (apply adjust, form n/z)
// Optional feature macro: DEC_NZ_FIX_EN (n/z taken from the corrected result).
package dec_adjust_pkg;

  localparam logic [7:0] ADJ_LO  = 8'h06;
  localparam logic [7:0] ADJ_HI  = 8'h60;
  localparam logic [7:0] BCD_MAX = 8'h99;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } flags_t;

  typedef enum logic {
    ADC = 1'b0,
    SBC = 1'b1
  } op_t;

  typedef struct packed {
    logic [7:0] adj;
    logic [7:0] bin;
    flags_t     flg;
  } front_t;

  typedef struct packed {
    logic [7:0] res;
    flags_t     flg;
  } back_t;

  function automatic back_t apply_adjust(input front_t f);
    back_t r;
    r.res = f.bin + f.adj;  // modulo-256 wrap is intended
    r.flg = f.flg;
`ifdef DEC_NZ_FIX_EN
    r.flg.n = r.res[7];
    r.flg.z = (r.res == 8'h00);
`endif
    return r;
  endfunction

endpackage

// File: rtl/dec_adjust_stage.sv
// dec_adjust_stage -- one valid/ready pipeline register.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   in_data [W-1:0]       : payload in
//   out_valid / out_ready : downstream handshake
//   out_data [W-1:0]      : registered payload out (held while stalled)
module dec_adjust_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Ready when empty or when the held entry leaves this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dec_adjust.sv
// dec_adjust -- pipelined BCD adjust and flag generation for an 8-bit ALU.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake
//   dec, sub              : decimal mode, operation (1 = SBC)
//   a, b                  : original operands (b un-inverted)
//   bin, hc, co           : binary adder result, carry out of bit 3 / bit 7
//   out_valid / out_ready : output handshake
//   res, c, n, z, v       : adjusted result and flags
// Parameter STAGES (1 or 2): pipeline depth.
// Optional feature macro: DEC_NZ_FIX_EN (n/z from corrected res; else from bin).
module dec_adjust
  import dec_adjust_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       dec,
  input  logic       sub,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] bin,
  input  logic       hc,
  input  logic       co,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] res,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);

  localparam int FW = $bits(front_t);
  localparam int BW = $bits(back_t);

  op_t    op;
  logic   lo_fix, hi_fix, bx7;
  front_t front;
  back_t  back_in, back_q;
  logic   unused_bits;

  assign op          = op_t'(sub);
  assign bx7         = b[7] ^ sub;
  assign unused_bits = ^{a[6:0], b[6:0]};

  always_comb begin
    front  = '0;
    lo_fix = (op == SBC) ? !hc : (hc || (bin[3:0] > 4'd9));
    hi_fix = (op == SBC) ? !co : (co || (bin > BCD_MAX));
    if (dec) begin
      if (lo_fix) front.adj = (op == SBC) ? front.adj - ADJ_LO : front.adj + ADJ_LO;
      if (hi_fix) front.adj = (op == SBC) ? front.adj - ADJ_HI : front.adj + ADJ_HI;
    end
    front.bin   = bin;
    front.flg.c = (dec && op == ADC) ? (co || (bin > BCD_MAX)) : co;
    front.flg.v = (a[7] ~^ bx7) & (a[7] ^ bin[7]);
    // NMOS flags come straight from the binary sum.
    front.flg.n = bin[7];
    front.flg.z = (bin == 8'h00);
  end

  generate
    if (STAGES == 1) begin : g_one
      assign back_in = apply_adjust(front);

      dec_adjust_stage #(.W(BW)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (back_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (back_q)
      );
    end else begin : g_two
      front_t s1_data;
      logic   s1_valid, s1_ready;

      dec_adjust_stage #(.W(FW)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (front),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_data)
      );

      assign back_in = apply_adjust(s1_data);

      dec_adjust_stage #(.W(BW)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (back_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (back_q)
      );
    end
  endgenerate

  assign res = back_q.res;
  assign c   = back_q.flg.c;
  assign n   = back_q.flg.n;
  assign z   = back_q.flg.z;
  assign v   = back_q.flg.v;

endmodule
